// File: rtl/id_stage.sv
// Decode stage: MIPS-subset main decoder feeding a 2-entry skid buffer.
// Decode happens on entry; outputs come straight from the main entry.
module id_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instruction,
   input  logic [31:0] pc_in,
   input  logic        flush,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] pc_out,
   output logic [4:0]  rs,
   output logic [4:0]  rt,
   output logic [4:0]  rd,
   output logic [4:0]  shamt,
   output logic [15:0] imm16,
   output logic [25:0] target,
   output logic        RegDst,
   output logic        ALUSrc,
   output logic        MemToReg,
   output logic        RegWrite,
   output logic        MemWrite,
   output logic        Branch,
   output logic        Jump,
   output logic        ExtOp,
   output logic [2:0]  ALUCtr,
   output logic        illegal
);

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_to_reg;
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       ext_op;
      logic [2:0] alu_ctr;
      logic       illegal;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [25:0] body;
      ctrl_t       ctrl;
   } entry_t;

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      FULL
   } state_t;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_OR  = 3'b010;
   localparam logic [2:0] ALU_SLT = 3'b011;
   localparam logic [2:0] ALU_LUI = 3'b100;

   state_t state, state_n;
   entry_t main_q, main_n;
   entry_t skid_q, skid_n;
   entry_t dec;
   logic   in_ready_q;
   logic   accept;
   logic   consume;

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = instruction[31:26];
   assign funct = instruction[5:0];

   always_comb begin
      dec      = '0;
      dec.pc   = pc_in;
      dec.body = instruction[25:0];
      // The all-zero word is a NOP and stays fully quiet.
      if (instruction != 32'h0) begin
         case (op)
            6'h00: begin
               dec.ctrl.reg_dst   = 1'b1;
               dec.ctrl.reg_write = 1'b1;
               case (funct)
                  6'h21:   dec.ctrl.alu_ctr = ALU_ADD;
                  6'h23:   dec.ctrl.alu_ctr = ALU_SUB;
                  6'h2A:   dec.ctrl.alu_ctr = ALU_SLT;
                  default: dec.ctrl = '{illegal: 1'b1, default: '0};
               endcase
            end
            6'h09: begin
               dec.ctrl.alu_src   = 1'b1;
               dec.ctrl.reg_write = 1'b1;
               dec.ctrl.ext_op    = 1'b1;
               dec.ctrl.alu_ctr   = ALU_ADD;
            end
            6'h0D: begin
               dec.ctrl.alu_src   = 1'b1;
               dec.ctrl.reg_write = 1'b1;
               dec.ctrl.alu_ctr   = ALU_OR;
            end
            6'h0F: begin
               dec.ctrl.alu_src   = 1'b1;
               dec.ctrl.reg_write = 1'b1;
               dec.ctrl.alu_ctr   = ALU_LUI;
            end
            6'h23: begin
               dec.ctrl.alu_src    = 1'b1;
               dec.ctrl.mem_to_reg = 1'b1;
               dec.ctrl.reg_write  = 1'b1;
               dec.ctrl.ext_op     = 1'b1;
               dec.ctrl.alu_ctr    = ALU_ADD;
            end
            6'h2B: begin
               dec.ctrl.alu_src   = 1'b1;
               dec.ctrl.mem_write = 1'b1;
               dec.ctrl.ext_op    = 1'b1;
               dec.ctrl.alu_ctr   = ALU_ADD;
            end
            6'h04: begin
               dec.ctrl.branch  = 1'b1;
               dec.ctrl.ext_op  = 1'b1;
               dec.ctrl.alu_ctr = ALU_SUB;
            end
            6'h02: dec.ctrl.jump = 1'b1;
            default: dec.ctrl.illegal = 1'b1;
         endcase
      end
   end

   assign accept  = in_valid & in_ready_q;
   assign consume = (state != EMPTY) & out_ready;

   always_comb begin
      state_n = state;
      main_n  = main_q;
      skid_n  = skid_q;
      if (flush) begin
         state_n = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  state_n = ONE;
                  main_n  = dec;
               end
            end
            ONE: begin
               if (accept && consume) begin
                  main_n = dec;
               end else if (accept) begin
                  state_n = FULL;
                  skid_n  = dec;
               end else if (consume) begin
                  state_n = EMPTY;
               end
            end
            FULL: begin
               if (consume) begin
                  state_n = ONE;
                  main_n  = skid_q;
               end
            end
            default: state_n = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_n;
         main_q     <= main_n;
         skid_q     <= skid_n;
         in_ready_q <= (state_n != FULL);
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state != EMPTY);
   assign pc_out    = main_q.pc;
   assign rs        = main_q.body[25:21];
   assign rt        = main_q.body[20:16];
   assign rd        = main_q.body[15:11];
   assign shamt     = main_q.body[10:6];
   assign imm16     = main_q.body[15:0];
   assign target    = main_q.body;
   assign RegDst    = main_q.ctrl.reg_dst;
   assign ALUSrc    = main_q.ctrl.alu_src;
   assign MemToReg  = main_q.ctrl.mem_to_reg;
   assign RegWrite  = main_q.ctrl.reg_write;
   assign MemWrite  = main_q.ctrl.mem_write;
   assign Branch    = main_q.ctrl.branch;
   assign Jump      = main_q.ctrl.jump;
   assign ExtOp     = main_q.ctrl.ext_op;
   assign ALUCtr    = main_q.ctrl.alu_ctr;
   assign illegal   = main_q.ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instruction;
   logic [31:0] pc_in;
   logic        flush;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] pc_out;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] target;
   logic        RegDst, ALUSrc, MemToReg, RegWrite, MemWrite;
   logic        Branch, Jump, ExtOp;
   logic [2:0]  ALUCtr;
   logic        illegal;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 0;

   logic [63:0] q[$];

   id_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .pc_in(pc_in),
      .flush(flush), .out_ready(out_ready),
      .out_valid(out_valid), .pc_out(pc_out),
      .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
      .imm16(imm16), .target(target),
      .RegDst(RegDst), .ALUSrc(ALUSrc),
      .MemToReg(MemToReg), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .Branch(Branch),
      .Jump(Jump), .ExtOp(ExtOp),
      .ALUCtr(ALUCtr), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // {illegal,RegDst,ALUSrc,MemToReg,RegWrite,MemWrite,Branch,Jump,ExtOp,ALUCtr}
   logic [11:0] dut_ctrl;
   assign dut_ctrl = {illegal, RegDst, ALUSrc, MemToReg, RegWrite,
                      MemWrite, Branch, Jump, ExtOp, ALUCtr};

   function automatic logic [11:0] ref_ctrl(input logic [31:0] w);
      if (w == 32'h0) return 12'h000;
      case (w[31:26])
         6'h00: case (w[5:0])
            6'h21:   return 12'b0_1_0_0_1_0_0_0_0_000;
            6'h23:   return 12'b0_1_0_0_1_0_0_0_0_001;
            6'h2A:   return 12'b0_1_0_0_1_0_0_0_0_011;
            default: return 12'h800;
         endcase
         6'h09:   return 12'b0_0_1_0_1_0_0_0_1_000;
         6'h0D:   return 12'b0_0_1_0_1_0_0_0_0_010;
         6'h0F:   return 12'b0_0_1_0_1_0_0_0_0_100;
         6'h23:   return 12'b0_0_1_1_1_0_0_0_1_000;
         6'h2B:   return 12'b0_0_1_0_0_1_0_0_1_000;
         6'h04:   return 12'b0_0_0_0_0_0_1_0_1_001;
         6'h02:   return 12'b0_0_0_0_0_0_0_1_0_000;
         default: return 12'h800;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of {pc, word} holding at most two entries.
   always @(negedge rst) q.delete();

   always @(posedge clk) begin
      if (!rst) begin
         q.delete();
      end else if (flush) begin
         q.delete();
      end else begin
         int  n;
         bit  acc, con;
         n   = q.size();
         acc = in_valid && (n < 2);
         con = (n > 0) && out_ready;
         if (con) void'(q.pop_front());
         if (acc) q.push_back({pc_in, instruction});
      end
   end

   always @(negedge clk) begin
      if (rst && chk_en) begin
         check("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
         check("m_in_ready", 64'(in_ready), 64'(q.size() < 2));
         if (q.size() > 0 && out_valid) begin
            logic [31:0] w, p;
            {p, w} = q[0];
            check("m_pc", 64'(pc_out), 64'(p));
            check("m_fields", {rs, rt, rd, shamt, imm16},
                  {w[25:21], w[20:16], w[15:11], w[10:6], w[15:0]});
            check("m_target", 64'(target), 64'(w[25:0]));
            check("m_ctrl", 64'(dut_ctrl), 64'(ref_ctrl(w)));
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] w,
                        input logic [31:0] p, input logic fl,
                        input logic ordy);
      in_valid    = v;
      instruction = w;
      pc_in       = p;
      flush       = fl;
      out_ready   = ordy;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_cleared(input string name);
      check({name, "_valid"}, 64'(out_valid), 64'd0);
      check({name, "_ready"}, 64'(in_ready), 64'd1);
      check({name, "_pc"}, 64'(pc_out), 64'd0);
      check({name, "_fields"}, {rs, rt, rd, shamt, target}, 64'd0);
      check({name, "_ctrl"}, 64'(dut_ctrl), 64'd0);
   endtask

   logic [31:0] pool [12] = '{
      32'h00221821, 32'h00221823, 32'h0022182A, 32'h24210005,
      32'h3421FFFF, 32'h3C011234, 32'h8E080004, 32'hAE080008,
      32'h1022FFFF, 32'h08000010, 32'h00000000, 32'h0000003F
   };

   initial begin
      rst = 1'b0;
      in_valid = 0; instruction = 0; pc_in = 0;
      flush = 0; out_ready = 0;
      repeat (3) @(negedge clk);
      check_cleared("reset");
      rst = 1'b1;
      chk_en = 1;

      // addu, one cycle latency
      drive(1, 32'h00221821, 32'h00003000, 0, 0);
      check("addu_valid", 64'(out_valid), 64'd1);
      check("addu_regs", {rs, rt, rd}, {5'd1, 5'd2, 5'd3});
      check("addu_ctrl", {RegDst, RegWrite, ALUCtr}, {1'b1, 1'b1, 3'b000});
      check("addu_pc", 64'(pc_out), 64'h3000);
      drive(0, 0, 0, 0, 1);

      // lw, sw, beq with three stalled cycles
      drive(1, 32'h8E080004, 32'h00003100, 0, 0);
      check("lw_ready1", 64'(in_ready), 64'd1);
      drive(1, 32'hAE080008, 32'h00003104, 0, 0);
      check("full_ready", 64'(in_ready), 64'd0);
      drive(1, 32'h1022FFFF, 32'h00003108, 0, 0);
      check("hold_lw", {rs, rt, imm16, MemToReg}, {5'd16, 5'd8, 16'h0004, 1'b1});
      check("hold_pc", 64'(pc_out), 64'h3100);
      drive(1, 32'h1022FFFF, 32'h00003108, 0, 1);
      check("sw_next", {MemWrite, pc_out}, {1'b1, 32'h3104});
      drive(1, 32'h1022FFFF, 32'h00003108, 0, 1);
      check("beq_next", {Branch, ALUCtr, imm16, pc_out},
            {1'b1, 3'b001, 16'hFFFF, 32'h3108});
      drive(0, 0, 0, 0, 1);
      check("drained", 64'(out_valid), 64'd0);

      // jump then flush with a lui offered
      drive(1, 32'h08000010, 32'h00003200, 0, 0);
      check("j_jump", {out_valid, Jump}, 2'b11);
      drive(1, 32'h3C011234, 32'h00003204, 1, 0);
      check("flush_valid", 64'(out_valid), 64'd0);
      check("flush_ready", 64'(in_ready), 64'd1);
      drive(0, 0, 0, 0, 1);
      check("no_lui", 64'(out_valid), 64'd0);

      // illegal and nop encodings
      drive(1, 32'hFC000000, 32'h00003300, 0, 1);
      check("ill_op", 64'(dut_ctrl), 64'h800);
      drive(1, 32'h0000003F, 32'h00003304, 0, 1);
      check("ill_fn", 64'(dut_ctrl), 64'h800);
      drive(1, 32'h00000000, 32'h00003308, 0, 1);
      check("nop", {out_valid, dut_ctrl}, {1'b1, 12'h000});
      drive(0, 0, 0, 0, 1);

      // back-to-back throughput
      for (int i = 0; i < 8; i++) begin
         drive(1, pool[i], 32'h3000 + 32'(4 * i), 0, 1);
         check("b2b_pc", {out_valid, pc_out}, {1'b1, 32'h3000 + 32'(4 * i)});
      end
      drive(0, 0, 0, 0, 1);

      // asynchronous reset while full
      drive(1, 32'h8E080004, 32'h00003400, 0, 0);
      drive(1, 32'hAE080008, 32'h00003404, 0, 0);
      check("pre_rst_full", 64'(in_ready), 64'd0);
      in_valid = 0;
      #3 rst = 1'b0;
      #1 check_cleared("async_rst");
      @(negedge clk);
      rst = 1'b1;
      drive(1, 32'h00221823, 32'h00004000, 0, 1);
      check("post_rst", {out_valid, pc_out, ALUCtr}, {1'b1, 32'h4000, 3'b001});
      drive(0, 0, 0, 0, 1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] w;
         w = ($urandom_range(3) == 0) ? $urandom : pool[$urandom_range(11)];
         drive(1'($urandom_range(3) != 0), w, $urandom,
               1'($urandom_range(31) == 0), 1'($urandom_range(2) != 0));
      end

      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
